// File: rtl/snurisc_run_ctrl.sv
// Run controller for a snurisc core: loads a program into IMEM over a
// valid/ready stream, releases the core from reset, gates its clock enable and reports status.
module snurisc_run_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CYC_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  input  logic              i_start,
  input  logic              i_clr,
  input  logic [CYC_W-1:0]  i_cycle_limit,
  input  logic              i_core_halt,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0] o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_core_clock_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [CYC_W-1:0]  o_cycles,
  output logic [ADDR_W:0]   o_loaded_words
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [ADDR_W:0]  WORD_ONE = (ADDR_W + 1)'(1);

  state_e              state_q;
  logic                ld_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [DATA_W-1:0]   imem_wdata_q;
  logic                core_reset_q;
  logic                clock_en_q;
  logic                busy_q;
  logic                done_q;
  logic                timeout_q;
  logic [CYC_W-1:0]    cycles_q;
  logic [ADDR_W:0]     loaded_q;

  logic                ld_accept;
  logic                at_top;
  logic [CYC_W-1:0]    cycles_d;
  logic                limit_hit;

  // ld_ready_q is 1 exactly in IDLE and LOAD, so it doubles as the load-phase qualifier.
  assign ld_accept = i_ld_valid & ld_ready_q;
  assign at_top    = &loaded_q[ADDR_W-1:0];
  assign cycles_d  = (&cycles_q) ? cycles_q : cycles_q + CYC_ONE;
  assign limit_hit = (i_cycle_limit != '0) && (cycles_d == i_cycle_limit);

  // NOTE: every output is a flop updated with its next-state value, so all
  // sequential assignments are non-blocking and nothing reaches a port combinationally.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      ld_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b0;
      clock_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycles_q     <= '0;
      loaded_q     <= '0;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_LOAD: begin
          if (ld_accept) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= loaded_q[ADDR_W-1:0];
            imem_wdata_q <= i_ld_data;
            loaded_q     <= loaded_q + WORD_ONE;
            if (i_ld_last || at_top) begin
              state_q    <= S_ARMED;
              ld_ready_q <= 1'b0;
            end else begin
              state_q    <= S_LOAD;
            end
          end
        end
        S_ARMED: begin
          if (i_start) begin
            state_q      <= S_RELEASE;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
          end
        end
        S_RELEASE: begin
          state_q    <= S_RUN;
          clock_en_q <= 1'b1;
        end
        S_RUN: begin
          cycles_q <= cycles_d;
          if (i_core_halt || limit_hit) begin
            state_q    <= S_DONE;
            clock_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            timeout_q  <= ~i_core_halt;
          end
        end
        S_DONE: begin
          if (i_clr) begin
            state_q      <= S_IDLE;
            ld_ready_q   <= 1'b1;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            loaded_q     <= '0;
          end else if (i_start) begin
            state_q      <= S_ARMED;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          ld_ready_q   <= 1'b1;
          core_reset_q <= 1'b0;
          clock_en_q   <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign o_ld_ready      = ld_ready_q;
  assign o_imem_we       = imem_we_q;
  assign o_imem_addr     = imem_addr_q;
  assign o_imem_wdata    = imem_wdata_q;
  assign o_core_reset    = core_reset_q;
  assign o_core_clock_en = clock_en_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_timeout       = timeout_q;
  assign o_cycles        = cycles_q;
  assign o_loaded_words  = loaded_q;

endmodule

// File: tb/tb_snurisc_run_ctrl.sv
// Scoreboard bench for snurisc_run_ctrl: a full-size instance for load/run/reset
// sequences and a 4-word instance for the implicit-last boundary.
module tb_snurisc_run_ctrl;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int CYC_W    = 32;
  localparam int S_ADDR_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              ld_valid = 1'b0, ld_last = 1'b0, start = 1'b0, clr = 1'b0, halt = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [CYC_W-1:0]  cycle_limit = '0;
  logic              ld_ready, imem_we, core_reset, clock_en, busy, done, timeout;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [CYC_W-1:0]  cycles;
  logic [ADDR_W:0]   loaded;

  logic                s_ld_valid = 1'b0;
  logic [DATA_W-1:0]   s_ld_data = '0;
  logic                s_ld_ready, s_imem_we, s_core_reset, s_clock_en, s_busy, s_done, s_timeout;
  logic [S_ADDR_W-1:0] s_imem_addr;
  logic [DATA_W-1:0]   s_imem_wdata;
  logic [CYC_W-1:0]    s_cycles;
  logic [S_ADDR_W:0]   s_loaded;

  snurisc_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_data(ld_data), .i_ld_last(ld_last),
    .i_start(start), .i_clr(clr), .i_cycle_limit(cycle_limit), .i_core_halt(halt),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_core_reset(core_reset), .o_core_clock_en(clock_en), .o_busy(busy), .o_done(done),
    .o_timeout(timeout), .o_cycles(cycles), .o_loaded_words(loaded)
  );

  snurisc_run_ctrl #(.ADDR_W(S_ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut_small (
    .i_clk(clk), .i_reset(rst_n),
    .i_ld_valid(s_ld_valid), .o_ld_ready(s_ld_ready), .i_ld_data(s_ld_data), .i_ld_last(1'b0),
    .i_start(1'b0), .i_clr(1'b0), .i_cycle_limit('0), .i_core_halt(1'b0),
    .o_imem_we(s_imem_we), .o_imem_addr(s_imem_addr), .o_imem_wdata(s_imem_wdata),
    .o_core_reset(s_core_reset), .o_core_clock_en(s_clock_en), .o_busy(s_busy), .o_done(s_done),
    .o_timeout(s_timeout), .o_cycles(s_cycles), .o_loaded_words(s_loaded)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  wr_t exp_s_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every IMEM strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    check("en_without_core_reset", 64'(clock_en & ~core_reset), 64'd0);
    if (imem_we) begin
      if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("imem_addr", 64'(imem_addr), 64'(e.addr));
        check("imem_wdata", 64'(imem_wdata), 64'(e.data));
      end
    end
    if (s_imem_we) begin
      if (exp_s_q.size() == 0) check("small_unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_s_q.pop_front();
        check("small_imem_addr", 64'(s_imem_addr), 64'(e.addr));
        check("small_imem_wdata", 64'(s_imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input bit gaps);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      check("ld_ready_before_beat", 64'(ld_ready), 64'd1);
      ld_valid = 1'b1;
      ld_data  = 32'h13 + 32'h80 * i;
      ld_last  = (i == n - 1);
      w.addr   = ADDR_W'(i);
      w.data   = ld_data;
      exp_q.push_back(w);
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (gaps && i != n - 1) step();
    end
    check("armed_ld_ready", 64'(ld_ready), 64'd0);
    check("loaded_words", 64'(loaded), 64'(n));
    check("armed_core_reset", 64'(core_reset), 64'd0);
    check("armed_busy", 64'(busy), 64'd0);
    step();
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_case(input int limit, input int halt_at, input int exp_cyc, input bit exp_to);
    int en_cnt = 0;
    int k = 0;
    cycle_limit = CYC_W'(limit);
    start = 1'b1;
    step();
    start = 1'b0;
    check("release_core_reset", 64'(core_reset), 64'd1);
    check("release_clock_en", 64'(clock_en), 64'd0);
    check("release_cycles", 64'(cycles), 64'd0);
    check("release_busy", 64'(busy), 64'd1);
    step();
    while (!done && k < 100) begin
      if (clock_en) en_cnt++;
      k++;
      if (k == halt_at) halt = 1'b1;
      step();
      halt = 1'b0;
    end
    check("run_finished_in_budget", 64'(k < 100), 64'd1);
    check("clock_en_cycles", 64'(en_cnt), 64'(exp_cyc));
    check("done_cycles", 64'(cycles), 64'(exp_cyc));
    check("done_timeout", 64'(timeout), 64'(exp_to));
    check("done_flag", 64'(done), 64'd1);
    check("done_clock_en", 64'(clock_en), 64'd0);
    check("done_core_reset", 64'(core_reset), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
  endtask

  task automatic rearm();
    start = 1'b1;
    step();
    start = 1'b0;
    check("rearm_core_reset", 64'(core_reset), 64'd0);
    check("rearm_done", 64'(done), 64'd0);
    check("rearm_loaded", 64'(loaded), 64'd4);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    wr_t w;
    #1;
    check("in_reset_core_reset", 64'(core_reset), 64'd0);
    check("in_reset_imem_we", 64'(imem_we), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("reset_ld_ready", 64'(ld_ready), 64'd1);
    check("reset_flags", 64'({busy, done, timeout, clock_en, core_reset}), 64'd0);
    check("reset_counters", 64'({cycles, 11'(loaded)}), 64'd0);
    check("reset_imem", 64'({imem_addr, imem_wdata}), 64'd0);

    load_words(4, 1'b0);
    run_case(5, 0, 5, 1'b1);
    rearm();
    run_case(0, 3, 3, 1'b0);
    rearm();
    run_case(3, 3, 3, 1'b0);

    start = 1'b1;
    clr   = 1'b1;
    step();
    start = 1'b0;
    clr   = 1'b0;
    check("clr_ld_ready", 64'(ld_ready), 64'd1);
    check("clr_loaded", 64'(loaded), 64'd0);
    check("clr_flags", 64'({done, timeout, core_reset}), 64'd0);

    load_words(3, 1'b1);

    cycle_limit = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("midrun_clock_en", 64'(clock_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_core_reset", 64'(core_reset), 64'd0);
    check("async_clock_en", 64'(clock_en), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_ld_ready", 64'(ld_ready), 64'd1);
    check("post_reset_cycles", 64'(cycles), 64'd0);
    check("post_reset_loaded", 64'(loaded), 64'd0);
    check("post_reset_flags", 64'({busy, done, timeout}), 64'd0);

    s_ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("small_ld_ready", 64'(s_ld_ready), 64'(i < 4));
      s_ld_data = 32'hA0 + i;
      if (i < 4) begin
        w.addr = ADDR_W'(i);
        w.data = s_ld_data;
        exp_s_q.push_back(w);
      end
      step();
    end
    s_ld_valid = 1'b0;
    check("small_loaded", 64'(s_loaded), 64'd4);
    check("small_armed_ready", 64'(s_ld_ready), 64'd0);
    step();
    check("small_writes_drained", 64'(exp_s_q.size()), 64'd0);
    check("main_writes_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
